// File: rtl/risc_run_controller_if.sv
// Bus between the run controller and the bench/processor wrapper.
// The master side drives start/abort and processor observations; the slave (controller) drives run control and status.
interface risc_run_controller_if #(
  parameter int PC_WIDTH   = 16,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 32
);
  logic                  start;
  logic                  abort;
  logic [PC_WIDTH-1:0]   pc;
  logic                  mem_wr_en;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic                  cpu_reset;
  logic                  cpu_en;
  logic                  running;
  logic                  done;
  logic [1:0]            status;
  logic [CNT_WIDTH-1:0]  cycle_count;
  logic [DATA_WIDTH-1:0] signature;

  modport master (
    output start, abort, pc, mem_wr_en, mem_wr_data,
    input  cpu_reset, cpu_en, running, done, status, cycle_count, signature
  );

  modport slave (
    input  start, abort, pc, mem_wr_en, mem_wr_data,
    output cpu_reset, cpu_en, running, done, status, cycle_count, signature
  );
endinterface

// File: rtl/risc_run_controller.sv
// Run controller for the 16-bit RISC sim flow: sequenced CPU reset, timeout, PC-stall halt detection.
// Optional memory-write signature enabled by defining RISC_RUN_SIGNATURE_EN.
module risc_run_controller #(
  parameter int PC_WIDTH       = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int CNT_WIDTH      = 32,
  parameter int RESET_CYCLES   = 2,
  parameter int STALL_LIMIT    = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic                   clk,
  input logic                   reset,
  risc_run_controller_if.slave  bus
);

  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HW-1:0]        HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [SW-1:0]        STALL_MAX = SW'(STALL_LIMIT);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, RESET_HOLD, RUN, DONE} state_t;

  state_t                state, state_nxt;
  logic [HW-1:0]         hold_cnt;
  logic [SW-1:0]         stall_cnt, stall_nxt;
  logic [PC_WIDTH-1:0]   pc_q;
  logic                  pc_valid;
  logic [CNT_WIDTH-1:0]  cycle_count_q, cnt_nxt;
  logic [1:0]            status_q, status_nxt;
  logic                  halt_hit, tmo_hit, enter_hold;
  logic                  cpu_reset_c, cpu_en_c, running_c, done_c;

  function automatic logic [SW-1:0] stall_inc(input logic [SW-1:0] v);
    return (v >= STALL_MAX) ? v : v + SW'(1);
  endfunction

  // Termination detection looks at the values the counters take on this edge.
  always_comb begin
    stall_nxt = (pc_valid && (bus.pc == pc_q)) ? stall_inc(stall_cnt) : '0;
    cnt_nxt   = cycle_count_q + CNT_WIDTH'(1);
    halt_hit  = (stall_nxt == STALL_MAX);
    tmo_hit   = (cnt_nxt == CNT_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    status_nxt  = status_q;
    enter_hold  = 1'b0;
    cpu_reset_c = 1'b0;
    cpu_en_c    = 1'b0;
    running_c   = 1'b0;
    done_c      = 1'b0;
    case (state)
      IDLE: begin
        cpu_reset_c = 1'b1;
        if (bus.start) begin
          state_nxt  = RESET_HOLD;
          enter_hold = 1'b1;
          status_nxt = 2'b00;
        end
      end
      RESET_HOLD: begin
        cpu_reset_c = 1'b1;
        if (bus.abort) begin
          state_nxt  = DONE;
          status_nxt = 2'b11;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        cpu_en_c  = 1'b1;
        running_c = 1'b1;
        if (bus.abort) begin
          state_nxt  = DONE;
          status_nxt = 2'b11;
        end else if (halt_hit) begin
          state_nxt  = DONE;
          status_nxt = 2'b01;
        end else if (tmo_hit) begin
          state_nxt  = DONE;
          status_nxt = 2'b10;
        end
      end
      DONE: begin
        done_c = 1'b1;
        if (bus.start) begin
          state_nxt  = RESET_HOLD;
          enter_hold = 1'b1;
          status_nxt = 2'b00;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Run bookkeeping: everything clears on entry to RESET_HOLD and only advances in RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt      <= '0;
      stall_cnt     <= '0;
      pc_q          <= '0;
      pc_valid      <= 1'b0;
      cycle_count_q <= '0;
      status_q      <= 2'b00;
    end else begin
      status_q <= status_nxt;
      if (enter_hold) begin
        hold_cnt      <= '0;
        stall_cnt     <= '0;
        pc_valid      <= 1'b0;
        cycle_count_q <= '0;
      end else if (state == RESET_HOLD) begin
        if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + HW'(1);
      end else if (state == RUN) begin
        cycle_count_q <= cnt_nxt;
        pc_q          <= bus.pc;
        pc_valid      <= 1'b1;
        stall_cnt     <= stall_nxt;
      end
    end
  end

`ifdef RISC_RUN_SIGNATURE_EN
  logic [DATA_WIDTH-1:0] sig_q;

  function automatic logic [DATA_WIDTH-1:0] sig_update(input logic [DATA_WIDTH-1:0] s,
                                                       input logic [DATA_WIDTH-1:0] d);
    return {s[DATA_WIDTH-2:0], s[DATA_WIDTH-1]} ^ d;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               sig_q <= '0;
    else if (enter_hold)                     sig_q <= '0;
    else if (state == RUN && bus.mem_wr_en)  sig_q <= sig_update(sig_q, bus.mem_wr_data);
  end

  assign bus.signature = sig_q;
`else
  logic unused_sig_inputs;
  assign unused_sig_inputs = ^{bus.mem_wr_en, bus.mem_wr_data};
  assign bus.signature     = '0;
`endif

  assign bus.cpu_reset   = cpu_reset_c;
  assign bus.cpu_en      = cpu_en_c;
  assign bus.running     = running_c;
  assign bus.done        = done_c;
  assign bus.status      = status_q;
  assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_risc_run_controller.sv
// Directed bench for risc_run_controller: halt, timeout, abort priority, reset/restart, signature.
module tb_risc_run_controller;

  localparam int PW = 16;
  localparam int DW = 16;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  risc_run_controller_if #(.PC_WIDTH(PW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  risc_run_controller #(
    .PC_WIDTH(PW), .DATA_WIDTH(DW), .CNT_WIDTH(CW),
    .RESET_CYCLES(2), .STALL_LIMIT(4), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start pulse, then two RESET_HOLD cycles, leaving the DUT in its first RUN cycle
  task automatic start_run(input string tag);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, "_rh1_cpu_reset"}, bus.cpu_reset, 1'b1);
    chk({tag, "_rh1_count"}, bus.cycle_count, 0);
    chk({tag, "_rh1_status"}, bus.status, 2'b00);
    tick();
    chk({tag, "_rh2_cpu_reset"}, bus.cpu_reset, 1'b1);
    chk({tag, "_rh2_cpu_en"}, bus.cpu_en, 1'b0);
    tick();
    chk({tag, "_run_cpu_reset"}, bus.cpu_reset, 1'b0);
    chk({tag, "_run_cpu_en"}, bus.cpu_en, 1'b1);
  endtask

  // halt pattern: pc 0..9 on RUN cycles 1..10, then held; optional abort on cycle 14
  task automatic halt_run(input string tag, input bit abort_at_14, input logic [1:0] exp_status);
    for (int k = 1; k <= 14; k++) begin
      bus.pc    = (k <= 10) ? PW'(k - 1) : 16'h0009;
      bus.abort = abort_at_14 && (k == 14);
      tick();
      if (k == 13) begin
        chk({tag, "_c13_running"}, bus.running, 1'b1);
        chk({tag, "_c13_done"}, bus.done, 1'b0);
      end
    end
    bus.abort = 1'b0;
    chk({tag, "_done"}, bus.done, 1'b1);
    chk({tag, "_running"}, bus.running, 1'b0);
    chk({tag, "_status"}, bus.status, exp_status);
    chk({tag, "_count"}, bus.cycle_count, 14);
    chk({tag, "_cpu_en"}, bus.cpu_en, 1'b0);
    chk({tag, "_cpu_reset"}, bus.cpu_reset, 1'b0);
  endtask

  initial begin
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.pc          = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_data = '0;
    #2;
    chk("rst_cpu_reset", bus.cpu_reset, 1'b1);
    chk("rst_cpu_en", bus.cpu_en, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_running", bus.running, 1'b0);
    chk("rst_status", bus.status, 2'b00);
    chk("rst_count", bus.cycle_count, 0);
    chk("rst_sig", bus.signature, 0);
    tick();
    tick();
    reset = 1'b0;

    // IDLE ignores abort
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("idle_abort_done", bus.done, 1'b0);
    chk("idle_cpu_reset", bus.cpu_reset, 1'b1);

    start_run("halt");
    halt_run("halt", 1'b0, 2'b01);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("done_hold_status", bus.status, 2'b01);
    chk("done_hold_count", bus.cycle_count, 14);
    chk("done_hold_done", bus.done, 1'b1);

    // timeout: pc always advances; a start pulse mid-run is ignored
    start_run("tmo");
    for (int k = 1; k <= 20; k++) begin
      bus.pc    = PW'(16'h0100 + k);
      bus.start = (k == 7);
      tick();
      if (k == 19) begin
        chk("tmo_c19_cpu_en", bus.cpu_en, 1'b1);
        chk("tmo_c19_count", bus.cycle_count, 19);
      end
    end
    bus.start = 1'b0;
    chk("tmo_done", bus.done, 1'b1);
    chk("tmo_status", bus.status, 2'b10);
    chk("tmo_count", bus.cycle_count, 20);
    chk("tmo_cpu_en", bus.cpu_en, 1'b0);

    start_run("abt");
    halt_run("abt", 1'b1, 2'b11);

    // abort while holding the processor in reset
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("rh_abort_done", bus.done, 1'b1);
    chk("rh_abort_status", bus.status, 2'b11);
    chk("rh_abort_count", bus.cycle_count, 0);

    // reset mid-run at RUN cycle 5, checked before any clock edge
    start_run("mid");
    for (int k = 1; k <= 4; k++) begin
      bus.pc = PW'(k);
      tick();
    end
    chk("mid_count4", bus.cycle_count, 4);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_cpu_reset", bus.cpu_reset, 1'b1);
    chk("mid_rst_cpu_en", bus.cpu_en, 1'b0);
    chk("mid_rst_running", bus.running, 1'b0);
    chk("mid_rst_count", bus.cycle_count, 0);
    chk("mid_rst_status", bus.status, 2'b00);
    tick();
    reset = 1'b0;

    // restart after reset, with two memory writes on RUN cycles 1 and 2
    start_run("rst2");
    bus.pc          = 16'h0040;
    bus.mem_wr_en   = 1'b1;
    bus.mem_wr_data = 16'h1234;
    tick();
    bus.pc          = 16'h0041;
    bus.mem_wr_data = 16'h00FF;
    tick();
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_data = 16'hFFFF;
    chk("rst2_count", bus.cycle_count, 2);
`ifdef RISC_RUN_SIGNATURE_EN
    chk("sig_value", bus.signature, 16'h2497);
`else
    chk("sig_value", bus.signature, 16'h0000);
`endif
    bus.pc = 16'h0042;
    tick();
`ifdef RISC_RUN_SIGNATURE_EN
    chk("sig_no_write", bus.signature, 16'h2497);
`else
    chk("sig_no_write", bus.signature, 16'h0000);
`endif
    chk("rst2_count3", bus.cycle_count, 3);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/risc_run_controller.md
# risc_run_controller

Parametrised run controller for the 16-bit RISC processor simulation flow. It replaces a fixed reset pulse and fixed simulation time with sequenced processor reset, a cycle-count timeout, halt detection (PC stuck) and an optional memory-write signature. It sits between the top-level bench and the `Risc_16_bit` instance. It drives the processor's reset and enable, and reports a pass/fail status for regression scripts.

## Interface
Parameters:
- PC_WIDTH, 16, width of the monitored program counter
- DATA_WIDTH, 16, width of the memory write data and of the signature
- CNT_WIDTH, 32, cycle counter width; must hold TIMEOUT_CYCLES
- RESET_CYCLES, 2, cycles for which cpu_reset is held after start (≥1)
- STALL_LIMIT, 4, consecutive equal-PC comparisons that declare a halt (≥1)
- TIMEOUT_CYCLES, 1000, maximum RUN cycles before a forced stop

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high; forces the IDLE state immediately
- start  in  1  single-cycle pulse; begins a run from IDLE or DONE
- abort  in  1  level; terminates a run in progress
- pc  in  PC_WIDTH  processor program counter
- mem_wr_en  in  1  processor data-memory write strobe
- mem_wr_data  in  DATA_WIDTH  processor data-memory write data
- cpu_reset  out  1  reset to the processor
- cpu_en  out  1  processor clock enable; 1 only in RUN
- running  out  1  1 while in RUN
- done  out  1  1 while in DONE
- status  out  2  termination cause: 00 none, 01 halt, 10 timeout, 11 abort
- cycle_count  out  CNT_WIDTH  number of RUN cycles completed
- signature  out  DATA_WIDTH  memory-write signature

## Operation
- States: IDLE, RESET_HOLD, RUN, DONE.
- Reset values: state=IDLE, cpu_reset=1, cpu_en=0, running=0, done=0, status=00, cycle_count=0, signature=0, stall counter=0, pc_valid=0.
- IDLE:
  - cpu_reset=1, cpu_en=0.
  - start → RESET_HOLD.
  - abort is ignored.
- On entry to RESET_HOLD:
  - Clear cycle_count, status, signature, the stall counter and pc_valid.
- RESET_HOLD:
  - cpu_reset=1 for exactly RESET_CYCLES cycles, then → RUN.
  - abort → DONE, status=11.
  - start is ignored.
- RUN:
  - cpu_reset=0, cpu_en=1, running=1.
  - cycle_count increments by 1 every cycle.
  - The PC is registered into pc_q each cycle, and pc_valid is set after the first RUN cycle.
  - If pc_valid and pc==pc_q, the stall counter increments; otherwise the stall counter clears.
- RUN termination conditions, evaluated on the same edge. Priority is abort > halt > timeout:
  - abort=1 → status=11.
  - The stall counter reaches STALL_LIMIT on this edge → status=01.
  - cycle_count reaches TIMEOUT_CYCLES on this edge → status=10.
  - On any of these, → DONE.
- DONE:
  - cpu_en=0 and cpu_reset=0, so processor state is frozen for inspection.
  - done=1.
  - status, cycle_count and signature are held.
  - start → RESET_HOLD (restart); abort is ignored.
- start received in RUN is ignored.
- Arithmetic:
  - The stall counter saturates at STALL_LIMIT.
  - cycle_count never exceeds TIMEOUT_CYCLES, so it does not wrap.

## Timing
- start sampled high at edge N: RESET_HOLD occupies cycles N+1 … N+RESET_CYCLES, and cpu_en=1 from cycle N+RESET_CYCLES+1.
- When a termination condition is true at edge M:
  - At edge M, running falls, done rises and status is valid, all together.
  - cycle_count equals the number of RUN cycles, including the terminating cycle.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Asserting reset mid-operation returns the block to its reset values without waiting for a clock edge. Deassertion is released on the next clk edge.

## Configuration
- Macro RISC_RUN_SIGNATURE_EN.
- Defined: in RUN, each cycle with mem_wr_en=1 updates the signature as signature ← rotate_left(signature,1) XOR mem_wr_data. The signature is cleared on entry to RESET_HOLD.
- Undefined: signature is tied to 0, and mem_wr_en and mem_wr_data are unused.

## Test plan
All scenarios use RESET_CYCLES=2, STALL_LIMIT=4, TIMEOUT_CYCLES=20.
- Reset check: assert reset with no clock edge → cpu_reset=1, cpu_en=0, done=0, status=00, cycle_count=0 immediately.
- Halt:
  - Stimulus: start pulse; pc=0…9 on RUN cycles 1–10, then pc held at 0x0009.
  - Required response: cpu_reset high for exactly 2 cycles, then done=1, status=01, cycle_count=14.
- Timeout: pc increments every cycle → done=1, status=10, cycle_count=20, and cpu_en falls on the same edge.
- Abort priority: abort asserted on the same edge as the halt detection of the halt scenario → status=11, cycle_count=14.
- Reset mid-run and restart:
  - Assert reset at RUN cycle 5 → IDLE values asynchronously.
  - A new start → full RESET_HOLD of 2 cycles, and cycle_count restarts from 0.
- Signature:
  - With RISC_RUN_SIGNATURE_EN defined, writes 0x1234 then 0x00FF → signature=0x2497.
  - Without the macro → signature=0x0000.
